ising_anneal_ctrl: RTL and testbench

- Sequencer and weight configurator for an N-oscillator coupled-RO Ising array (N×N coupled cells).
- Holds the 3-bit coupling weight of every cell, accepts weight writes over a valid/ready port, and runs one anneal: hold oscillators off, release, count run time, synchronise and sample oscillator phases.
- Presents the resulting spin vector to the host with a done pulse.

---
 rtl/ising_pkg.sv | 25 ++
 rtl/ising_anneal_ctrl_phase_sync.sv | 23 ++
 rtl/ising_anneal_ctrl.sv | 148 ++++++++++++++
 tb/tb_ising_anneal_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// rtl/ising_pkg.sv - weight codes, sequencer states and code check shared by the anneal controller
package ising_pkg;

  localparam logic [2:0] W_NEG2 = 3'd0;
  localparam logic [2:0] W_NEG1 = 3'd1;
  localparam logic [2:0] W_ZERO = 3'b010;
  localparam logic [2:0] W_POS1 = 3'd3;
  localparam logic [2:0] W_POS2 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SYNC   = 3'd3,
    ST_SAMPLE = 3'd4
  } state_t;

  function automatic logic weight_legal(input logic [2:0] code);
    case (code)
      W_NEG2, W_NEG1, W_ZERO, W_POS1, W_POS2: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ising_anneal_ctrl_phase_sync.sv
// rtl/ising_anneal_ctrl_phase_sync.sv - N-bit two-flop synchroniser for free-running oscillator phases
module phase_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ising_anneal_ctrl.sv
// rtl/ising_anneal_ctrl.sv - weight store and anneal sequencer for a coupled-RO Ising array
// Optional weight readback port enabled by ISING_WEIGHT_READBACK_EN.
module ising_anneal_ctrl
  import ising_pkg::*;
#(
  parameter int N           = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int RUN_W       = 16,
  parameter int AW          = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_data,
  output logic             wr_err,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  output logic             busy,
  output logic [3*N*N-1:0] weights,
  output logic             osc_en,
  input  logic [N-1:0]     osc_phase,
`ifdef ISING_WEIGHT_READBACK_EN
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  output logic [2:0]       rd_data,
  output logic             rd_ack,
`endif
  output logic [N-1:0]     spins,
  output logic             done
);

  localparam int NC = N*N;

  state_t           state;
  logic [2:0]       w_mem [NC];
  logic [RUN_W-1:0] cnt;
  logic [RUN_W-1:0] run_lat;
  logic [N-1:0]     sync_phase;
  logic [31:0]      addr_w;
  logic             wr_fire;
  logic             wr_bad;

  phase_sync #(.N(N)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (osc_phase),
    .q    (sync_phase)
  );

  assign wr_ready = (state == ST_IDLE) && rstn;
  assign wr_fire  = wr_valid && wr_ready;
  assign addr_w   = 32'(wr_addr);

  // Self-coupling cells and codes above +2 are rejected without touching storage.
  always_comb begin
    wr_bad = 1'b0;
    if (!weight_legal(wr_data) || addr_w >= NC || (addr_w / N) == (addr_w % N))
      wr_bad = 1'b1;
  end

  genvar k;
  generate
    for (k = 0; k < NC; k++) begin : g_flat
      assign weights[3*k +: 3] = w_mem[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      run_lat <= '0;
      busy    <= 1'b0;
      osc_en  <= 1'b0;
      spins   <= '0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
      for (int i = 0; i < NC; i++) w_mem[i] <= W_ZERO;
    end else begin
      done   <= 1'b0;
      wr_err <= 1'b0;
      if (wr_fire) begin
        wr_err <= wr_bad;
        if (!wr_bad) w_mem[wr_addr] <= wr_data;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_HOLD;
            busy    <= 1'b1;
            cnt     <= '0;
            run_lat <= (run_len == '0) ? RUN_W'(1) : run_len;
          end
        end
        ST_HOLD: begin
          if (cnt == RUN_W'(HOLD_CYCLES - 1)) begin
            state  <= ST_RUN;
            cnt    <= '0;
            osc_en <= 1'b1;
          end else begin
            cnt <= cnt + RUN_W'(1);
          end
        end
        ST_RUN: begin
          if (cnt == run_lat - RUN_W'(1)) begin
            state <= ST_SYNC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + RUN_W'(1);
          end
        end
        ST_SYNC: begin
          // Two cycles let the latest phases clear both synchroniser stages.
          if (cnt == RUN_W'(1)) begin
            state <= ST_SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + RUN_W'(1);
          end
        end
        ST_SAMPLE: begin
          spins  <= sync_phase ^ {N{sync_phase[0]}};
          done   <= 1'b1;
          osc_en <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ISING_WEIGHT_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ack  <= 1'b0;
      rd_data <= W_ZERO;
    end else begin
      rd_ack <= rd_valid;
      if (rd_valid)
        rd_data <= (32'(rd_addr) < NC) ? w_mem[rd_addr] : W_ZERO;
    end
  end
`endif

endmodule

// File: tb/tb_ising_anneal_ctrl.sv
// tb/tb_ising_anneal_ctrl.sv - randomized scoreboard bench for ising_anneal_ctrl
module tb_ising_anneal_ctrl;

  localparam int N     = 8;
  localparam int HOLD  = 4;
  localparam int RUN_W = 16;
  localparam int AW    = 6;
  localparam int NC    = N*N;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [2:0]       wr_data;
  logic             wr_err;
  logic             start;
  logic [RUN_W-1:0] run_len;
  logic             busy;
  logic [3*NC-1:0]  weights;
  logic             osc_en;
  logic [N-1:0]     osc_phase;
  logic [N-1:0]     spins;
  logic             done;

  always #5 clk = ~clk;

  ising_anneal_ctrl #(.N(N), .HOLD_CYCLES(HOLD), .RUN_W(RUN_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .start     (start),
    .run_len   (run_len),
    .busy      (busy),
    .weights   (weights),
    .osc_en    (osc_en),
    .osc_phase (osc_phase),
    .spins     (spins),
    .done      (done)
  );

  typedef struct {
    int           due;
    logic [N-1:0] sp;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           w_model [NC];
  logic [N-1:0] last_sp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [3*NC-1:0] act, input logic [3*NC-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic logic [3*NC-1:0] model_flat();
    logic [3*NC-1:0] f;
    for (int i = 0; i < NC; i++) f[3*i +: 3] = 3'(w_model[i]);
    return f;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding anneal.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.due);
          check("spins", spins, e.sp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input int data);
    logic bad;
    bad = (data > 4) || (addr / N == addr % N);
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_data  = 3'(data);
    check("wr_ready", wr_ready, 1);
    if (!bad) w_model[addr] = data;
    tick();
    wr_valid = 1'b0;
    check("wr_err", wr_err, bad);
    check("weights", weights, model_flat());
  endtask

  task automatic issue_start(input int rl, input logic [N-1:0] ph);
    exp_t e;
    osc_phase = ph;
    run_len   = RUN_W'(rl);
    start     = 1'b1;
    e.due = cyc + 1 + HOLD + ((rl == 0) ? 1 : rl) + 3;
    e.sp  = ph ^ {N{ph[0]}};
    last_sp = e.sp;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
    check("busy_idle", busy, 0);
  endtask

  task automatic phase_hold_check();
    osc_phase = N'($urandom);
    repeat (4) tick();
    check("spins_hold", spins, last_sp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; run_len = '0; osc_phase = '0;
    for (int i = 0; i < NC; i++) w_model[i] = 2;
    repeat (3) tick();
    check("rst_weights", weights, model_flat());
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_spins", spins, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_wr_ready", wr_ready, 0);
    rstn = 1'b1;
    tick();

    do_write(1, 4);
    check("w1_field", weights[5:3], 3'b100);
    do_write(9, 3);
    do_write(2, 6);
    check("w2_field", weights[8:6], 3'b010);
    check("w9_field", weights[29:27], 3'b010);

    // Directed run with mid-run write attempt.
    issue_start(10, 8'b1010_0101);
    for (int k = 1; k <= 16; k++) begin
      if (k == 8) begin
        wr_valid = 1'b1; wr_addr = AW'(3); wr_data = 3'd1;
      end
      tick();
      if (k == 9) begin
        wr_valid = 1'b0;
        check("midrun_weights", weights, model_flat());
        check("midrun_wr_err", wr_err, 0);
      end
      check("run_wr_ready", wr_ready, 0);
      check("run_busy", busy, 1);
      check("run_osc_en", osc_en, k >= 4);
    end
    wait_idle();
    check("done_osc_en", osc_en, 0);
    check("spins_directed", spins, 8'b0101_1010);
    phase_hold_check();

    // run_len=0 with restarts while busy.
    issue_start(0, 8'b0011_1100);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_idle();
    repeat (20) tick();
    phase_hold_check();

    // Write and start in the same cycle: run must see the new weight.
    begin
      exp_t e;
      wr_valid = 1'b1; wr_addr = AW'(10); wr_data = 3'd0;
      osc_phase = 8'hC3; run_len = 16'd3; start = 1'b1;
      w_model[10] = 0;
      e.due = cyc + 1 + HOLD + 3 + 3;
      e.sp  = 8'hC3 ^ 8'hFF;
      last_sp = e.sp;
      exp_q.push_back(e);
      tick();
      wr_valid = 1'b0; start = 1'b0;
      check("simul_weights", weights, model_flat());
      wait_idle();
    end

    // Random writes interleaved with random anneals.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 8; j++) do_write($urandom_range(0, NC-1), $urandom_range(0, 7));
      issue_start($urandom_range(0, 25), N'($urandom));
      wait_idle();
      check("rand_spins", spins, last_sp);
      phase_hold_check();
    end

    // Reset during RUN: no done afterwards, everything back to reset values.
    issue_start(10, 8'h5A);
    repeat (6) tick();
    check("pre_rst_osc_en", osc_en, 1);
    void'(exp_q.pop_back());
    rstn = 1'b0;
    tick();
    check("rst_mid_wr_ready", wr_ready, 0);
    rstn = 1'b1;
    for (int i = 0; i < NC; i++) w_model[i] = 2;
    last_sp = '0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_osc_en", osc_en, 0);
    check("rst_mid_weights", weights, model_flat());
    check("rst_mid_spins", spins, 0);
    check("rst_mid_done", done, 0);
    repeat (25) tick();
    check("rst_mid_spins_later", spins, 0);
    check("rst_mid_busy_later", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
